// File: rtl/periph_cfg_arbiter_if.sv
// Requester-side and target-side bus bundle for periph_cfg_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface periph_cfg_arbiter_if #(
  parameter int unsigned NB_REQ   = 2,
  parameter int unsigned ID_WIDTH = 9
);
  logic [NB_REQ-1:0]               req_i;
  logic [NB_REQ-1:0][31:0]         add_i;
  logic [NB_REQ-1:0]               wen_i;
  logic [NB_REQ-1:0][31:0]         wdata_i;
  logic [NB_REQ-1:0][3:0]          be_i;
  logic [NB_REQ-1:0][ID_WIDTH-1:0] id_i;
  logic [NB_REQ-1:0]               gnt_o;
  logic [NB_REQ-1:0]               r_valid_o;
  logic [31:0]                     r_rdata_o;
  logic                            r_opc_o;
  logic [ID_WIDTH-1:0]             r_id_o;

  logic                            tgt_req_o;
  logic [31:0]                     tgt_add_o;
  logic                            tgt_wen_o;
  logic [31:0]                     tgt_wdata_o;
  logic [3:0]                      tgt_be_o;
  logic [ID_WIDTH-1:0]             tgt_id_o;
  logic                            tgt_gnt_i;
  logic                            tgt_r_valid_i;
  logic [31:0]                     tgt_r_rdata_i;
  logic                            tgt_r_opc_i;
  logic [ID_WIDTH-1:0]             tgt_r_id_i;

  logic                            err_o;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, id_i,
    output gnt_o, r_valid_o, r_rdata_o, r_opc_o, r_id_o,
    output tgt_req_o, tgt_add_o, tgt_wen_o, tgt_wdata_o, tgt_be_o, tgt_id_o,
    input  tgt_gnt_i, tgt_r_valid_i, tgt_r_rdata_i, tgt_r_opc_i, tgt_r_id_i,
    output err_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, id_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_opc_o, r_id_o,
    input  tgt_req_o, tgt_add_o, tgt_wen_o, tgt_wdata_o, tgt_be_o, tgt_id_o,
    output tgt_gnt_i, tgt_r_valid_i, tgt_r_rdata_i, tgt_r_opc_i, tgt_r_id_i,
    input  err_o
  );
endinterface

// File: rtl/periph_cfg_arbiter.sv
// N-to-1 arbiter for a peripheral config target with in-order response routing.
// Define PERIPH_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module periph_cfg_arbiter #(
  parameter int unsigned NB_REQ    = 2,
  parameter int unsigned ID_WIDTH  = 9,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  periph_cfg_arbiter_if.slave bus_io
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned AW    = $clog2(MAX_OUTST);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [AW:0]      ptr_t;
  typedef enum logic { IDLE, HOLD } state_e;

  state_e              state_q, state_d;
  idx_t                win_q, win_d;
  ptr_t                wptr_q, wptr_d;
  ptr_t                rptr_q, rptr_d;
  logic                err_q, err_d;
  idx_t                fifo_q [MAX_OUTST];

  logic                arb_any;
  idx_t                arb_win;
  idx_t                sel;
  logic                push;
  logic                treq;
  logic                full;
  logic                empty;
  logic [NB_REQ-1:0]   gnt;
  logic [NB_REQ-1:0]   rvalid;
  logic [ID_WIDTH-1:0] id_sel;

`ifdef PERIPH_ARB_RR_EN
  idx_t rr_q, rr_d;
  idx_t cand;
  logic arb_hit;
`endif

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  always_comb begin
    arb_any = |bus_io.req_i;
    arb_win = '0;
`ifdef PERIPH_ARB_RR_EN
    cand    = '0;
    arb_hit = 1'b0;
    // Search starts at the priority pointer and wraps around the requesters.
    for (int k = 0; k < NB_REQ; k++) begin
      cand = idx_t'((32'(rr_q) + 32'(k)) % NB_REQ);
      if (!arb_hit && bus_io.req_i[cand]) begin
        arb_win = cand;
        arb_hit = 1'b1;
      end
    end
`else
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      if (bus_io.req_i[k]) arb_win = idx_t'(k);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    err_d   = err_q;
    sel     = arb_win;
    treq    = 1'b0;
    push    = 1'b0;
    gnt     = '0;
    rvalid  = '0;
`ifdef PERIPH_ARB_RR_EN
    rr_d    = rr_q;
`endif

    case (state_q)
      IDLE: begin
        // Fullness comes from registered pointers, so a same-cycle pop cannot unblock.
        if (arb_any && !full) begin
          treq = 1'b1;
          if (bus_io.tgt_gnt_i) begin
            push = 1'b1;
          end else begin
            state_d = HOLD;
            win_d   = arb_win;
          end
        end
      end
      HOLD: begin
        sel = win_q;
        if (bus_io.req_i[win_q]) begin
          treq = 1'b1;
          if (bus_io.tgt_gnt_i) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if (push) begin
      gnt[sel] = 1'b1;
      wptr_d   = wptr_q + 1'b1;
`ifdef PERIPH_ARB_RR_EN
      rr_d     = (sel == idx_t'(NB_REQ - 1)) ? '0 : sel + 1'b1;
`endif
    end

    if (bus_io.tgt_r_valid_i) begin
      if (!empty) begin
        rvalid[fifo_q[rptr_q[AW-1:0]]] = 1'b1;
        rptr_d = rptr_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      win_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      err_q   <= 1'b0;
`ifdef PERIPH_ARB_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      err_q   <= err_d;
`ifdef PERIPH_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Grantee storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= sel;
  end

  assign id_sel = bus_io.id_i[sel];

  // Combinational outputs are forced low while reset is asserted.
  assign bus_io.gnt_o       = rst_ni ? gnt : '0;
  assign bus_io.r_valid_o   = rst_ni ? rvalid : '0;
  assign bus_io.r_rdata_o   = rst_ni ? bus_io.tgt_r_rdata_i : '0;
  assign bus_io.r_opc_o     = rst_ni & bus_io.tgt_r_opc_i;
  assign bus_io.r_id_o      = rst_ni ? bus_io.tgt_r_id_i : '0;
  assign bus_io.tgt_req_o   = rst_ni & treq;
  assign bus_io.tgt_add_o   = (rst_ni && treq) ? bus_io.add_i[sel]   : '0;
  assign bus_io.tgt_wen_o   = rst_ni & treq & bus_io.wen_i[sel];
  assign bus_io.tgt_wdata_o = (rst_ni && treq) ? bus_io.wdata_i[sel] : '0;
  assign bus_io.tgt_be_o    = (rst_ni && treq) ? bus_io.be_i[sel]    : '0;
  assign bus_io.tgt_id_o    = (rst_ni && treq) ? id_sel              : '0;
  assign bus_io.err_o       = err_q;

endmodule

// File: tb/tb_periph_cfg_arbiter.sv
// Randomized and directed bench for periph_cfg_arbiter against a queue-based reference model.
module tb_periph_cfg_arbiter;
  localparam int NB  = 2;
  localparam int MO  = 4;
  localparam int IDW = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  periph_cfg_arbiter_if #(.NB_REQ(NB), .ID_WIDTH(IDW)) bus ();

  periph_cfg_arbiter #(.NB_REQ(NB), .ID_WIDTH(IDW), .MAX_OUTST(MO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: held winner (-1 none), outstanding grantees, priority pointer, sticky error.
  int held  = -1;
  int rr    = 0;
  int q[$];
  bit err_m = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NB-1:0] r);
    int start;
    start = 0;
`ifdef PERIPH_ARB_RR_EN
    start = rr;
`endif
    for (int k = 0; k < NB; k++) begin
      if (r[(start + k) % NB]) return (start + k) % NB;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.req_i         = '0;
    bus.add_i         = '0;
    bus.wen_i         = '0;
    bus.wdata_i       = '0;
    bus.be_i          = '0;
    bus.id_i          = '0;
    bus.tgt_gnt_i     = 1'b0;
    bus.tgt_r_valid_i = 1'b0;
    bus.tgt_r_rdata_i = '0;
    bus.tgt_r_opc_i   = 1'b0;
    bus.tgt_r_id_i    = '0;
  endtask

  // Called just after a rising edge with inputs set; checks mid-cycle, advances the model at the edge.
  task automatic cycle();
    int sel, nxt_held, head;
    bit push, full, do_err;
    logic [NB-1:0] eg, ev;
    #4;
    full = (q.size() == MO);
    sel = -1; push = 1'b0; nxt_held = held; head = -1; do_err = 1'b0;
    eg = '0; ev = '0;
    if (held >= 0) begin
      if (bus.req_i[held]) begin
        sel = held;
        if (bus.tgt_gnt_i) begin
          push = 1'b1;
          nxt_held = -1;
        end
      end else begin
        nxt_held = -1;
      end
    end else if (bus.req_i != '0 && !full) begin
      sel = pick(bus.req_i);
      if (bus.tgt_gnt_i) push = 1'b1;
      else nxt_held = sel;
    end
    if (push) eg[sel] = 1'b1;
    if (bus.tgt_r_valid_i) begin
      if (q.size() > 0) begin
        head = q[0];
        ev[head] = 1'b1;
      end else begin
        do_err = 1'b1;
      end
    end

    check_eq("gnt", bus.gnt_o, eg);
    check_eq("tgt_req", bus.tgt_req_o, (sel >= 0));
    if (sel >= 0) begin
      check_eq("tgt_add", bus.tgt_add_o, bus.add_i[sel]);
      check_eq("tgt_wen", bus.tgt_wen_o, bus.wen_i[sel]);
      check_eq("tgt_wdata", bus.tgt_wdata_o, bus.wdata_i[sel]);
      check_eq("tgt_be", bus.tgt_be_o, bus.be_i[sel]);
      check_eq("tgt_id", bus.tgt_id_o, bus.id_i[sel]);
    end
    check_eq("r_valid", bus.r_valid_o, ev);
    if (bus.tgt_r_valid_i) begin
      check_eq("r_rdata", bus.r_rdata_o, bus.tgt_r_rdata_i);
      check_eq("r_opc", bus.r_opc_o, bus.tgt_r_opc_i);
      check_eq("r_id", bus.r_id_o, bus.tgt_r_id_i);
    end
    check_eq("err", bus.err_o, err_m);

    @(posedge clk);
    if (head >= 0) void'(q.pop_front());
    if (push) begin
      q.push_back(sel);
      rr = (sel + 1) % NB;
    end
    if (do_err) err_m = 1'b1;
    held = nxt_held;
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    idle_inputs();
    rst_n = 1'b0;
    #4;
    check_eq("rst_gnt", bus.gnt_o, 0);
    check_eq("rst_r_valid", bus.r_valid_o, 0);
    check_eq("rst_tgt_req", bus.tgt_req_o, 0);
    check_eq("rst_tgt_add", bus.tgt_add_o, 0);
    check_eq("rst_err", bus.err_o, 0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    held  = -1;
    rr    = 0;
    err_m = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    idle_inputs();
    bus.tgt_r_valid_i = 1'b1;
    bus.tgt_r_rdata_i = data;
    bus.tgt_r_id_i    = IDW'(data);
    cycle();
  endtask

  task automatic request(input logic [NB-1:0] r, input bit g);
    idle_inputs();
    bus.req_i = r;
    for (int h = 0; h < NB; h++) begin
      bus.add_i[h]   = 32'h1000_0000 + 32'(h * 16 + n_total);
      bus.wdata_i[h] = 32'hD000_0000 + 32'(h);
      bus.be_i[h]    = 4'hF;
      bus.id_i[h]    = IDW'(h + 3);
      bus.wen_i[h]   = h[0];
    end
    bus.tgt_gnt_i = g;
    cycle();
  endtask

  initial begin
    idle_inputs();
    #1;
    apply_reset(2);

    // Single read from requester 1, response next cycle.
    idle_inputs();
    bus.req_i = 2'b10;
    bus.add_i[1] = 32'h1000_0400;
    bus.wen_i[1] = 1'b1;
    bus.id_i[1]  = 9'h055;
    bus.tgt_gnt_i = 1'b1;
    cycle();
    respond(32'hCAFE_0001);

    // Both requesting for four back-to-back granted cycles, then drain.
    repeat (4) request(2'b11, 1'b1);
    repeat (4) respond($urandom);

    // Grant stall: requester 1 held while requester 0 joins.
    request(2'b10, 1'b0);
    request(2'b11, 1'b0);
    request(2'b11, 1'b0);
    request(2'b11, 1'b1);
    request(2'b11, 1'b1);
    repeat (2) respond($urandom);

    // Full FIFO: a same-cycle response does not unblock.
    repeat (4) request(2'b01, 1'b1);
    idle_inputs();
    bus.req_i = 2'b01;
    bus.tgt_gnt_i = 1'b1;
    bus.tgt_r_valid_i = 1'b1;
    bus.tgt_r_rdata_i = 32'h0000_0077;
    cycle();
    request(2'b01, 1'b1);
    repeat (4) respond($urandom);

    // Grants to 0, 1, 1 then responses A, B, C.
    request(2'b01, 1'b1);
    request(2'b10, 1'b1);
    request(2'b10, 1'b1);
    respond(32'hA);
    respond(32'hB);
    respond(32'hC);

    // Spurious response sets the sticky error.
    respond(32'hBAD0_0000);
    repeat (3) request(2'b00, 1'b0);
    apply_reset(1);

    // Transactions granted before a reset respond after it.
    request(2'b01, 1'b1);
    request(2'b10, 1'b1);
    apply_reset(1);
    respond(32'h5555_0000);
    request(2'b00, 1'b0);
    apply_reset(1);

    // Randomized traffic, including dropped requests while held.
    for (int c = 0; c < 600; c++) begin
      bus.req_i = NB'($urandom_range(0, 3));
      for (int h = 0; h < NB; h++) begin
        bus.add_i[h]   = $urandom;
        bus.wdata_i[h] = $urandom;
        bus.be_i[h]    = 4'($urandom);
        bus.id_i[h]    = IDW'($urandom);
        bus.wen_i[h]   = 1'($urandom);
      end
      bus.tgt_gnt_i     = ($urandom_range(0, 2) != 0);
      bus.tgt_r_valid_i = ($urandom_range(0, 2) == 0);
      bus.tgt_r_rdata_i = $urandom;
      bus.tgt_r_opc_i   = 1'($urandom);
      bus.tgt_r_id_i    = IDW'($urandom);
      cycle();
      if (c == 300) apply_reset(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
